// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam int CNT_W = 4;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM with byte-lane writes and registered read
module dmem_array #(
    parameter int ADDR_W = 6,
    parameter int INIT_ZERO = 1
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic              err,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    logic [31:0] mem [2**ADDR_W] = '{default: (INIT_ZERO != 0) ? 32'h0 : 32'hx};
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[idx];
            if (we && !err)
                for (int i = 0; i < 4; i++)
                    if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: req/gnt/rvalid data-memory responder with wait states and range check
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int WAIT_CYCLES = 1,
    parameter int INIT_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        gnt,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic we_q, err_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0] wdata_q, mem_rdata;
    logic [3:0] be_q;
    logic idle, accept, in_err, commit, unused_addr;
    assign idle = state == IDLE;
    assign accept = idle && req;
    assign in_err = |addr[31:ADDR_W+2];
    assign unused_addr = ^addr[1:0];
    // with no wait states the commit coincides with acceptance, so use the live request
    assign commit = rst && (idle ? accept && WAIT_CYCLES == 0 : state == WAIT && cnt == '0);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = IDLE;
        state_nxt = idle ? (req ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE)
                  : state == WAIT ? (cnt == '0 ? RESP : WAIT) : IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            we_q <= 1'b0;
            err_q <= 1'b0;
            idx_q <= '0;
            wdata_q <= '0;
            be_q <= '0;
        end else if (accept) begin
            cnt <= CNT_W'(WAIT_CYCLES - 1);
            we_q <= we;
            err_q <= in_err;
            idx_q <= addr[ADDR_W+1:2];
            wdata_q <= wdata;
            be_q <= be;
        end else if (state == WAIT) begin
            cnt <= cnt - 1'b1;
        end
    end
    dmem_array #(.ADDR_W(ADDR_W), .INIT_ZERO(INIT_ZERO)) u_array (
        .clk  (clk),
        .en   (commit),
        .we   (idle ? we : we_q),
        .err  (idle ? in_err : err_q),
        .be   (idle ? be : be_q),
        .idx  (idle ? addr[ADDR_W+1:2] : idx_q),
        .wdata(idle ? wdata : wdata_q),
        .rdata(mem_rdata)
    );
    assign gnt = idle;
    assign rvalid = state == RESP;
    assign err = rvalid && err_q;
    assign rdata = (rvalid && !we_q && !err_q) ? mem_rdata : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of three responders against a word-array model
module tb_dmem_responder;
    localparam int WCS [3] = '{2, 3, 0};
    logic clk = 1'b0;
    logic rst [3];
    logic req [3], we [3], gnt [3], rvalid [3], err [3];
    logic [31:0] addr [3], wdata [3], rdata [3];
    logic [3:0] be [3];
    logic [31:0] mdl [3][64];
    logic [31:0] last_rdata;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(.ADDR_W(6), .WAIT_CYCLES(WCS[g]), .INIT_ZERO(1)) u_dut (
            .clk(clk), .rst(rst[g]), .req(req[g]), .we(we[g]), .addr(addr[g]),
            .wdata(wdata[g]), .be(be[g]), .gnt(gnt[g]), .rvalid(rvalid[g]),
            .rdata(rdata[g]), .err(err[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // one full transaction: expectation from the model, then handshake, latency and response checks
    task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b);
        int n;
        bit oor;
        logic [31:0] exp_r, merged;
        oor = a[31:8] != 0;
        merged = mdl[d][a[7:2]];
        for (int i = 0; i < 4; i++) if (b[i]) merged[8*i +: 8] = wd[8*i +: 8];
        exp_r = (oor || w) ? 32'h0 : mdl[d][a[7:2]];
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
        n = 0;
        while (!gnt[d] && n < 20) begin @(negedge clk); n++; end
        check($sformatf("d%0d gnt_wait", d), 32'(n < 20), 1);
        @(negedge clk);
        req[d] = 1'b0; we[d] = 1'($urandom); addr[d] = $urandom; wdata[d] = $urandom; be[d] = 4'($urandom);
        n = 1;
        while (!rvalid[d] && n < 20) begin @(negedge clk); n++; end
        check($sformatf("d%0d latency", d), n, WCS[d] + 1);
        check($sformatf("d%0d rdata a=%h", d, a), rdata[d], exp_r);
        check($sformatf("d%0d err a=%h", d, a), err[d], oor);
        last_rdata = rdata[d];
        if (w && !oor) mdl[d][a[7:2]] = merged;
    endtask

    initial begin
        logic [31:0] a, wds [3], as [3];
        int n;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0; be[d] = '0;
            for (int i = 0; i < 64; i++) mdl[d][i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) rst[d] = 1'b1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d rst_gnt", d), gnt[d], 1);
            check($sformatf("d%0d rst_rvalid", d), rvalid[d], 0);
            check($sformatf("d%0d rst_rdata", d), rdata[d], 0);
            check($sformatf("d%0d rst_err", d), err[d], 0);
        end
        txn(0, 1, 32'h10, 32'hDEADBEEF, dmem_pkg::BE_WORD);
        txn(0, 0, 32'h10, 32'h0, dmem_pkg::BE_NONE);
        check("word_load", last_rdata, 32'hDEADBEEF);
        txn(0, 1, 32'h20, 32'h11223344, 4'b1111);
        txn(0, 1, 32'h20, 32'h0000AA00, 4'b0010);
        txn(0, 0, 32'h22, 32'h0, 4'b0000);
        check("byte_merge", last_rdata, 32'h1122AA44);
        txn(0, 1, 32'h0, 32'hCAFE0001, 4'b1111);
        txn(0, 1, 32'h100, 32'hFFFFFFFF, 4'b1111);
        txn(0, 0, 32'h100, 32'h0, 4'b0000);
        txn(0, 0, 32'h0, 32'h0, 4'b0000);
        check("oor_no_alias", last_rdata, 32'hCAFE0001);
        txn(0, 1, 32'h30, 32'h5A5A5A5A, dmem_pkg::BE_NONE);
        txn(0, 0, 32'h30, 32'h0, 4'b0000);
        check("be_none_noop", last_rdata, 32'h0);
        for (int k = 0; k < 120; k++) begin
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[31:8] = '0;
            txn(0, 1'($urandom), a, $urandom, 4'($urandom));
        end
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h04; wdata[1] = 32'h12345678; be[1] = 4'b1111;
        check("mid_gnt", gnt[1], 1);
        @(negedge clk);
        req[1] = 1'b0;
        rst[1] = 1'b0;
        n = 0;
        repeat (3) begin @(negedge clk); n += int'(rvalid[1]); end
        rst[1] = 1'b1;
        check("mid_rel_gnt", gnt[1], 1);
        repeat (5) begin @(negedge clk); n += int'(rvalid[1]); end
        check("mid_no_rvalid", n, 0);
        txn(1, 0, 32'h04, 32'h0, 4'b0000);
        check("mid_discard", last_rdata, 32'h0);
        for (int k = 0; k < 3; k++) begin
            as[k] = {24'h0, 6'(k * 7 + 3), 2'b00};
            wds[k] = $urandom;
            txn(2, 1, as[k], wds[k], 4'b1111);
        end
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = as[0]; be[2] = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("b2b gnt k=%0d", k), gnt[2], 32'(k % 2 == 0));
            check($sformatf("b2b rvalid k=%0d", k), rvalid[2], 32'(k % 2 == 1));
            if (k % 2 == 1) begin
                check($sformatf("b2b rdata k=%0d", k), rdata[2], wds[k / 2]);
                if (k < 5) addr[2] = as[(k + 1) / 2];
                else req[2] = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b idle", rvalid[2], 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory bus responder; serves load/store requests from the CPU's memory stage over a req/gnt/rvalid handshake.
- Replaces the fixed-timing DMem, so the CPU control unit can stall on memory wait states.
- Word-organised storage with byte-enable writes and configurable access latency.
- Flags out-of-range accesses with an error response instead of aliasing them.

Parameters:
- ADDR_W, 6, word-address width; storage depth is 2**ADDR_W words (default 64 words, byte addresses 0x000-0x0FF).
- WAIT_CYCLES, 1, extra cycles between acceptance and response (0..15).
- INIT_ZERO, 1, when 1 the array is zero-filled at elaboration; otherwise contents are undefined.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  initiator request valid; held with its payload until gnt is seen high.
- we  in  1  1 = store, 0 = load.
- addr  in  32  byte address; bits [1:0] ignored; word index is addr[ADDR_W+1:2].
- wdata  in  32  store data, byte lanes already aligned by the initiator.
- be  in  4  byte enables; be[i] writes wdata[8i+7:8i].
- gnt  out  1  responder idle and accepting; a transaction is accepted on a rising edge with req=1 and gnt=1.
- rvalid  out  1  one-cycle response strobe.
- rdata  out  32  full word read, valid while rvalid=1; 0 for stores and errors.
- err  out  1  valid while rvalid=1; out-of-range access.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; gnt=1; rvalid=0; rdata=0; err=0; wait counter=0.
  - Array contents are not touched by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - gnt=1.
  - On req=1, capture we/addr/wdata/be into request registers.
  - Next state is WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0; otherwise RESP.
- WAIT:
  - gnt=0.
  - Counter decrements each cycle; leave for RESP on the cycle counter==0.
- Commit point: on the edge entering RESP, the array is read (registered word) and, for a store, written under be.
- RESP:
  - rvalid=1 for exactly one cycle; gnt=0; then IDLE unconditionally.
  - No backpressure on the response.
- Latency: the response appears WAIT_CYCLES+1 cycles after the acceptance edge.
- Throughput: one transaction per WAIT_CYCLES+2 cycles; req held high yields gnt again in the cycle after RESP.
- Load:
  - rdata = stored word (old value).
  - Byte/half extraction and sign extension belong to the CPU, not this block.
- Store:
  - Only enabled lanes change.
  - be=4'b0000 is a legal no-op, responding rvalid=1, err=0.
  - rdata=0.
- Range check: addr[31:ADDR_W+2] != 0 gives err=1, rdata=0, and no array write. Timing is identical to a normal access.
- Store followed by load to the same word returns the new data (commit precedes the next acceptance).
- Reset mid-transaction (WAIT or RESP): the transaction is aborted.
  - A store not yet committed is discarded.
  - No rvalid is produced.
  - After reset release, gnt=1 in the first cycle.
- Inputs outside IDLE are ignored; request registers change only on acceptance.
- All outputs are registered or decoded from state only; no combinational path from req to gnt/rvalid.

Decomposition:
- Package dmem_pkg holds:
  - state typedef (IDLE/WAIT/RESP);
  - BE_WORD=4'b1111, BE_NONE=4'b0000;
  - the WAIT_CYCLES counter width constant (4 bits).
- Sub-module dmem_array:
  - single-port synchronous RAM, 2**ADDR_W x 32;
  - inputs en, we, be, idx, wdata; output registered rdata;
  - no reset; written only when en & we & ~err.
- The FSM, range check and request registers stay in dmem_responder.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release -> gnt=1, rvalid=0, rdata=0, err=0 on the first post-reset cycle.
- Word store/load (WAIT_CYCLES=2): store addr=0x10, wdata=0xDEADBEEF, be=1111; then load 0x10 -> each rvalid arrives 3 cycles after acceptance; load rdata=0xDEADBEEF, err=0.
- Byte merge: word 0x20 holds 0x11223344; store be=0010, wdata=0x0000AA00; load 0x20 -> rdata=0x1122AA44.
- Out of range (ADDR_W=6): store addr=0x100, wdata=0xFFFFFFFF; load 0x100 and 0x000 ->
  - both 0x100 responses have err=1, rdata=0;
  - the load of 0x000 returns its prior value, unchanged.
- Reset mid-op (WAIT_CYCLES=3): accept store to 0x04 (old 0x0, new 0x12345678), assert rst during WAIT ->
  - no rvalid is produced;
  - after release, load 0x04 returns 0x00000000.
- Back-to-back (WAIT_CYCLES=0): hold req=1 over three loads ->
  - gnt pattern 1,0,1,0,1;
  - rvalid one cycle after each acceptance;
  - rdata in order.
